bit_unstuffer: RTL and testbench
================================

// Module: bit_unstuffer
// PURPOSE
//   USB receive-path bit destuffer. Sits between the RX NRZI decoder and the RX shift register.
//   Counts consecutive ones. Drops the stuffed zero that follows every run of RUN_LEN ones.
//   Regenerates a gapped shift enable for downstream logic. Flags a stuff error when the bit
//   after a full run is a one.
// PARAMETERS
//   RUN_LEN  6  ones in a run that forces a stuffed zero (USB = 6)
//   CNT_W    4  run-counter width; must satisfy 2**CNT_W > RUN_LEN
// PORTS
//   clk               in   1      system clock; single clock domain
//   rst               in   1      reset; synchronous, active-high
//   sync_clear        in   1      SOP/EOP pulse from RX control: clears run count, state, error
//   serial_in         in   1      NRZI-decoded data bit; valid only when shift_enable=1
//   shift_enable      in   1      one-cycle pulse per received bit period
//   d_orig            out  1      destuffed data bit (registered)
//   shift_enable_out  out  1      one-cycle pulse; d_orig is valid; absent for dropped bits
//   stuff_detect      out  1      one-cycle pulse; a stuffed zero was removed
//   stuff_error       out  1      sticky; a one followed a full run; held until sync_clear or rst
//   ones_count        out  CNT_W  current run length (debug and verification visibility)
// BEHAVIOUR
//   Reset and clear values
//   - rst=1 at a clock edge: state=HUNT; ones_count=0; d_orig=0; shift_enable_out=0;
//     stuff_detect=0; stuff_error=0.
//   - sync_clear=1 (rst=0) at a clock edge: same effect as rst.
//   - sync_clear beats shift_enable in the same cycle: that bit is discarded, no output pulse.
//   - rst mid-operation (any state) applies the same values immediately.
//   Timing
//   - All outputs are registered. Latency is exactly 1 clk from the sampled shift_enable to
//     shift_enable_out / stuff_detect.
//   - No assumption on spacing between shift_enable pulses; back-to-back pulses are legal.
//   - In cycles with shift_enable=0, state and count hold; output pulses deassert.
//   HUNT state (on shift_enable=1)
//   - serial_in=1: ones_count+1; forward the bit (d_orig=1, shift_enable_out=1).
//     If the new count == RUN_LEN, go to STRIP.
//   - serial_in=0: ones_count=0; forward the bit (d_orig=0, shift_enable_out=1).
//   - The RUN_LEN-th one is always forwarded. Only the following bit is dropped.
//   STRIP state (on shift_enable=1)
//   - The bit is never forwarded: shift_enable_out=0; d_orig holds its previous value.
//   - serial_in=0: stuff_detect=1 for one cycle; ones_count=0; go to HUNT.
//   - serial_in=1: stuff_error=1 (sticky); go to ERROR.
//   ERROR state
//   - Every shift_enable is swallowed: shift_enable_out=0, stuff_detect=0.
//   - ones_count holds. Exit only via sync_clear or rst.
//   Counter rules
//   - ones_count saturates at RUN_LEN and never wraps.
//   - A zero in HUNT, or a stuffed zero in STRIP, restarts it at 0.
// STRUCTURE
//   - Package usb_rx_pkg:
//     typedef enum logic [1:0] {HUNT, STRIP, ERROR} unstuff_state_t;
//     localparam int USB_STUFF_RUN = 6.
//   - One sub-module: ones_run_counter.
//     Synchronous active-high reset, clear, count_enable, saturating at a rollover value,
//     with an at_max flag.
//   - The top level holds the FSM and the output registers.
// TESTING
//   1. Feed 1,1,1,1,1,1,0 -> six shift_enable_out pulses with d_orig=1; zero dropped;
//      stuff_detect pulses once, 1 clk after the 7th shift_enable; ones_count returns to 0.
//   2. Feed 1,1,1,1,1,1,1 -> six forwarded; stuff_error rises 1 clk after the 7th shift_enable.
//      Further bits produce no shift_enable_out until sync_clear.
//   3. Feed 1,1,1,1,1,0,1 -> all seven forwarded unchanged; stuff_detect never pulses;
//      final ones_count=1.
//   4. Feed 1,1,1,1,1, assert sync_clear, then 1,1,0 -> the three bits after the clear are
//      forwarded; no strip, because the run restarted.
//   5. Reach STRIP (six ones), assert rst for 1 clk, then feed 0 -> the zero is forwarded;
//      all outputs were 0 during rst.
//   6. Feed (1x6,0) twice with back-to-back shift_enable -> 12 ones out, 2 stuff_detect pulses,
//      stuff_error=0. Repeat with random idle gaps -> identical output sequence.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

    typedef enum logic [1:0] {HUNT, STRIP, ERROR} unstuff_state_t;

    localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/bit_unstuffer_ones_run_counter.sv
// Saturating run counter; at_max reports that the post-update value equals MAX.
module ones_run_counter #(
    parameter int MAX = 6,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_enable,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] next_count;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_count = count;
        if (clear)
            next_count = '0;
        else if (count_enable && count != W'(MAX))
            next_count = count + 1'b1;
        at_max = (next_count == W'(MAX));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)
            count <= '0;
        else
            count <= next_count;
    end

endmodule

// File: rtl/bit_unstuffer.sv
// USB RX bit destuffer: forwards data bits, drops the zero stuffed after each run of ones.
module bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clear,
    input  logic             serial_in,
    input  logic             shift_enable,
    output logic             d_orig,
    output logic             shift_enable_out,
    output logic             stuff_detect,
    output logic             stuff_error,
    output logic [CNT_W-1:0] ones_count
);

    unstuff_state_t state, next_state;
    logic cnt_clr, cnt_en, cnt_at_max;
    logic d_next, seo_next, sd_next, err_next;

    // Counter controls depend only on state and inputs, keeping at_max free of feedback.
    always_comb begin
        cnt_clr = sync_clear;
        cnt_en  = 1'b0;
        if (!sync_clear && shift_enable) begin
            unique case (state)
                HUNT: begin
                    cnt_en  = serial_in;
                    cnt_clr = !serial_in;
                end
                STRIP:   cnt_clr = !serial_in;
                default: ;
            endcase
        end
    end

    ones_run_counter #(.MAX(RUN_LEN), .W(CNT_W)) u_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clr),
        .count_enable (cnt_en),
        .count        (ones_count),
        .at_max       (cnt_at_max)
    );

    always_comb begin
        next_state = state;
        d_next     = d_orig;
        seo_next   = 1'b0;
        sd_next    = 1'b0;
        err_next   = stuff_error;
        if (sync_clear) begin
            next_state = HUNT;
            d_next     = 1'b0;
            err_next   = 1'b0;
        end else if (shift_enable) begin
            unique case (state)
                HUNT: begin
                    seo_next = 1'b1;
                    d_next   = serial_in;
                    if (serial_in && cnt_at_max)
                        next_state = STRIP;
                end
                STRIP: begin
                    if (serial_in) begin
                        err_next   = 1'b1;
                        next_state = ERROR;
                    end else begin
                        sd_next    = 1'b1;
                        next_state = HUNT;
                    end
                end
                ERROR:   ;
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HUNT;
            d_orig           <= 1'b0;
            shift_enable_out <= 1'b0;
            stuff_detect     <= 1'b0;
            stuff_error      <= 1'b0;
        end else begin
            state            <= next_state;
            d_orig           <= d_next;
            shift_enable_out <= seo_next;
            stuff_detect     <= sd_next;
            stuff_error      <= err_next;
        end
    end

endmodule

// File: tb/tb_bit_unstuffer.sv
// Directed self-checking bench for bit_unstuffer; outputs packed as {seo,d,sd,err,cnt}.
module tb_bit_unstuffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_clear = 1'b0;
    logic       serial_in = 1'b0;
    logic       shift_enable = 1'b0;
    logic       d_orig, shift_enable_out, stuff_detect, stuff_error;
    logic [3:0] ones_count;

    int vectors = 0;
    int miscompares = 0;
    int n_fwd, n_sd;
    logic       cur_d;
    logic [3:0] cur_cnt;

    bit_unstuffer #(.RUN_LEN(6), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .sync_clear       (sync_clear),
        .serial_in        (serial_in),
        .shift_enable     (shift_enable),
        .d_orig           (d_orig),
        .shift_enable_out (shift_enable_out),
        .stuff_detect     (stuff_detect),
        .stuff_error      (stuff_error),
        .ones_count       (ones_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then check the registered outputs just after the edge.
    task automatic step(input logic se, input logic b, input logic clr, input logic r,
                        input string tag, input logic eseo, input logic ed, input logic esd,
                        input logic eerr, input logic [3:0] ecnt);
        shift_enable = se;
        serial_in    = b;
        sync_clear   = clr;
        rst          = r;
        @(posedge clk);
        #1;
        if (shift_enable_out === 1'b1) n_fwd++;
        if (stuff_detect === 1'b1)     n_sd++;
        chk(tag, {3'b000, shift_enable_out, d_orig, stuff_detect, stuff_error, ones_count},
                 {3'b000, eseo, ed, esd, eerr, ecnt});
        shift_enable = 1'b0;
        sync_clear   = 1'b0;
        rst          = 1'b0;
    endtask

    // One (1x6,0) frame, optionally with random idle gaps before each bit.
    task automatic frame(input string tag, input bit gaps);
        for (int k = 0; k < 7; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++)
                    step(0, 0, 0, 0, {tag, ".idle"}, 0, cur_d, 0, 0, cur_cnt);
            end
            if (k < 6) begin
                cur_d   = 1'b1;
                cur_cnt = 4'(k + 1);
                step(1, 1, 0, 0, {tag, ".one"}, 1, 1, 0, 0, cur_cnt);
            end else begin
                cur_cnt = 4'd0;
                step(1, 0, 0, 0, {tag, ".strip"}, 0, 1, 1, 0, 4'd0);
            end
        end
    endtask

    initial begin
        n_fwd = 0;
        n_sd  = 0;

        step(0, 0, 0, 1, "reset0", 0, 0, 0, 0, 4'd0);
        step(1, 1, 0, 1, "reset1", 0, 0, 0, 0, 4'd0);

        // 1: six ones then the stuffed zero
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 0, "t1.one", 1, 1, 0, 0, 4'(i + 1));
        step(1, 0, 0, 0, "t1.strip", 0, 1, 1, 0, 4'd0);
        step(0, 0, 0, 0, "t1.idle", 0, 1, 0, 0, 4'd0);

        // 2: seven ones -> sticky error, bits swallowed until sync_clear
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 0, "t2.one", 1, 1, 0, 0, 4'(i + 1));
        step(1, 1, 0, 0, "t2.err", 0, 1, 0, 1, 4'd6);
        step(1, 0, 0, 0, "t2.swallow0", 0, 1, 0, 1, 4'd6);
        step(1, 1, 0, 0, "t2.swallow1", 0, 1, 0, 1, 4'd6);
        step(0, 0, 0, 0, "t2.hold", 0, 1, 0, 1, 4'd6);
        step(0, 0, 1, 0, "t2.clear", 0, 0, 0, 0, 4'd0);

        // 3: five ones, zero, one -> all forwarded
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 0, "t3.one", 1, 1, 0, 0, 4'(i + 1));
        step(1, 0, 0, 0, "t3.zero", 1, 0, 0, 0, 4'd0);
        step(1, 1, 0, 0, "t3.last", 1, 1, 0, 0, 4'd1);

        // 4: sync_clear mid-run (coincident with a bit, which is discarded)
        step(0, 0, 1, 0, "t4.pre", 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 0, "t4.one", 1, 1, 0, 0, 4'(i + 1));
        step(1, 1, 1, 0, "t4.clear", 0, 0, 0, 0, 4'd0);
        step(1, 1, 0, 0, "t4.a", 1, 1, 0, 0, 4'd1);
        step(1, 1, 0, 0, "t4.b", 1, 1, 0, 0, 4'd2);
        step(1, 0, 0, 0, "t4.c", 1, 0, 0, 0, 4'd0);

        // 5: reset while in STRIP, then the zero must be forwarded
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 0, "t5.one", 1, 1, 0, 0, 4'(i + 1));
        step(1, 1, 0, 1, "t5.rst", 0, 0, 0, 0, 4'd0);
        step(1, 0, 0, 0, "t5.zero", 1, 0, 0, 0, 4'd0);

        // 6: two frames back-to-back, then two frames with idle gaps
        cur_d   = 1'b0;
        cur_cnt = 4'd0;
        n_fwd   = 0;
        n_sd    = 0;
        frame("t6.b2b", 1'b0);
        frame("t6.b2b", 1'b0);
        chk("t6.b2b.fwd", 8'(n_fwd), 8'd12);
        chk("t6.b2b.sd", 8'(n_sd), 8'd2);
        n_fwd = 0;
        n_sd  = 0;
        frame("t6.gap", 1'b1);
        frame("t6.gap", 1'b1);
        chk("t6.gap.fwd", 8'(n_fwd), 8'd12);
        chk("t6.gap.sd", 8'(n_sd), 8'd2);
        step(0, 0, 0, 0, "t6.end", 0, 1, 0, 0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
